// File: rtl/game_state_ctrl.sv
// Snake game sequencer: game_state FSM, step gating, direction filter.
// Optional PAUSE state enabled by defining GAME_PAUSE_EN.
module game_state_ctrl #(
  parameter int unsigned START_HOLD_FRAMES = 30,
  parameter int unsigned END_HOLD_FRAMES   = 120
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       frame_tick,
  input  logic       upd_tick,
  input  logic       btn_start,
  input  logic       dir_req_valid,
  input  logic [1:0] dir_req,
  input  logic       game_over_in,
  input  logic       game_won_in,
  output logic [2:0] game_state,
  output logic [1:0] direction,
  output logic       step_en,
  output logic       logic_reset_p
);

  typedef enum logic [2:0] {
    S_START  = 3'b000,
    S_INGAME = 3'b001,
    S_PAUSE  = 3'b010,
    S_OVER   = 3'b011,
    S_WON    = 3'b100
  } state_t;

  localparam logic [7:0] START_HOLD = START_HOLD_FRAMES[7:0];
  localparam logic [7:0] END_HOLD   = END_HOLD_FRAMES[7:0];

  state_t     state;
  state_t     state_n;
  logic [7:0] frame_cnt;
  logic [1:0] pending;
  logic       upd_d;
  logic       stay_ingame;

  always_comb begin
    state_n       = state;
    logic_reset_p = 1'b1;
    case (state)
      S_START: begin
        if (btn_start && frame_cnt >= START_HOLD)
          state_n = S_INGAME;
      end
      S_INGAME: begin
        logic_reset_p = 1'b0;
        if (game_over_in)
          state_n = S_OVER;
        else if (game_won_in)
          state_n = S_WON;
`ifdef GAME_PAUSE_EN
        else if (btn_start)
          state_n = S_PAUSE;
`endif
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        logic_reset_p = 1'b0;
        if (game_over_in)
          state_n = S_OVER;
        else if (game_won_in)
          state_n = S_WON;
        else if (btn_start)
          state_n = S_INGAME;
      end
`endif
      S_OVER, S_WON: begin
        logic_reset_p = 1'b0;
        if (btn_start && frame_cnt >= END_HOLD)
          state_n = S_START;
      end
      default: state_n = S_START;
    endcase
    if (!sys_reset_n)
      state_n = S_START;
  end

  // Steps only fire while play continues through this cycle
  assign stay_ingame = (state == S_INGAME) && (state_n == S_INGAME);
  assign step_en     = upd_d && stay_ingame;
  assign game_state  = state;

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state     <= S_START;
      direction <= 2'b11;
      pending   <= 2'b11;
      frame_cnt <= 8'd0;
      upd_d     <= 1'b0;
    end else begin
      state <= state_n;
      upd_d <= upd_tick && stay_ingame;
      if (state_n != state)
        frame_cnt <= 8'd0;
      else if (frame_tick && frame_cnt != 8'hff)
        frame_cnt <= frame_cnt + 8'd1;
      if (state_n == S_START && state != S_START) begin
        direction <= 2'b11;
        pending   <= 2'b11;
      end else if (state == S_START) begin
        if (dir_req_valid) begin
          direction <= dir_req;
          pending   <= dir_req;
        end
      end else if (state == S_INGAME) begin
        // Reversal is judged against the committed heading
        if (dir_req_valid && dir_req != (direction ^ 2'b01))
          pending <= dir_req;
        if (step_en)
          direction <= pending;
      end
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized bench for game_state_ctrl against a rule-level model.
// Define GAME_PAUSE_EN on both files to exercise the pause build.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, upd_tick, btn_start;
  logic       dir_req_valid, game_over_in, game_won_in;
  logic [1:0] dir_req;
  logic [2:0] game_state;
  logic [1:0] direction;
  logic       step_en, logic_reset_p;

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .sys_clk      (clk),
    .sys_reset_n  (rst_n),
    .frame_tick   (frame_tick),
    .upd_tick     (upd_tick),
    .btn_start    (btn_start),
    .dir_req_valid(dir_req_valid),
    .dir_req      (dir_req),
    .game_over_in (game_over_in),
    .game_won_in  (game_won_in),
    .game_state   (game_state),
    .direction    (direction),
    .step_en      (step_en),
    .logic_reset_p(logic_reset_p)
  );

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int START = 0, INGAME = 1, PAUSE = 2, OVER = 3, WON = 4;
  localparam int START_HOLD = 30, END_HOLD = 120;

  int checks = 0, errors = 0, steps_seen = 0;
  int m_state, m_frames, m_dir, m_pend;
  bit m_armed;
  int opp [4] = '{1, 0, 3, 2};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int next_mode(bit btn, bit ov, bit wn);
    case (m_state)
      START:  return (btn && m_frames >= START_HOLD) ? INGAME : START;
      INGAME: begin
        if (ov) return OVER;
        if (wn) return WON;
        if (PAUSE_EN && btn) return PAUSE;
        return INGAME;
      end
      PAUSE: begin
        if (ov) return OVER;
        if (wn) return WON;
        if (btn) return INGAME;
        return PAUSE;
      end
      default: return (btn && m_frames >= END_HOLD) ? START : m_state;
    endcase
  endfunction

  task automatic model_reset();
    m_state = START; m_frames = 0;
    m_dir = 3; m_pend = 3; m_armed = 1'b0;
  endtask

  task automatic cyc(bit rs, bit btn, bit upd, bit frm,
                     bit dv, logic [1:0] dr, bit ov, bit wn);
    int nxt, old_pend;
    bit exp_step;
    rst_n = rs; btn_start = btn; upd_tick = upd; frame_tick = frm;
    dir_req_valid = dv; dir_req = dr; game_over_in = ov; game_won_in = wn;
    @(negedge clk);
    nxt = rs ? next_mode(btn, ov, wn) : START;
    exp_step = m_armed && m_state == INGAME && nxt == INGAME;
    check("state", 32'(game_state), m_state);
    check("dir", 32'(direction), m_dir);
    check("step_en", 32'(step_en), 32'(exp_step));
    check("logic_reset", 32'(logic_reset_p), 32'(m_state == START));
    if (step_en) steps_seen++;
    @(posedge clk);
    #1;
    if (!rs) begin
      model_reset();
    end else begin
      m_armed = upd && m_state == INGAME && nxt == INGAME;
      if (nxt != m_state) begin
        m_frames = 0;
        if (nxt == START) begin m_dir = 3; m_pend = 3; end
      end else if (frm && m_frames < 255) begin
        m_frames++;
      end
      if (m_state == START) begin
        if (dv) begin m_dir = int'(dr); m_pend = int'(dr); end
      end else if (m_state == INGAME) begin
        old_pend = m_pend;
        if (dv && int'(dr) != opp[m_dir]) m_pend = int'(dr);
        if (exp_step) m_dir = old_pend;
      end
      m_state = nxt;
    end
  endtask

  task automatic run(int n, bit frm);
    repeat (n) cyc(1, 0, 0, frm, 0, 2'd0, 0, 0);
  endtask

  initial begin
    int s0;
    rst_n = 0; btn_start = 1; upd_tick = 1; frame_tick = 1;
    dir_req_valid = 1; dir_req = 2'd0; game_over_in = 1; game_won_in = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    // Reset state with busy inputs
    cyc(0, 1, 1, 1, 1, 2'd2, 1, 1);
    check("rst_state", 32'(game_state), 0);
    check("rst_dir", 32'(direction), 3);
    check("rst_lrp", 32'(logic_reset_p), 1);

    // 1: early start dropped, late start accepted
    run(5, 1);
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
    check("t1_early", 32'(game_state), 0);
    run(26, 1);
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
    check("t1_state", 32'(game_state), 1);
    check("t1_lrp", 32'(logic_reset_p), 0);

    // 2: single step, heading unchanged
    s0 = steps_seen;
    cyc(1, 0, 1, 0, 0, 2'd0, 0, 0);
    run(2, 0);
    check("t2_steps", steps_seen - s0, 1);
    check("t2_dir", 32'(direction), 3);

    // 3: reversal ignored, two quick turns
    cyc(1, 0, 0, 0, 1, 2'd2, 0, 0);
    cyc(1, 0, 0, 0, 1, 2'd0, 0, 0);
    cyc(1, 0, 0, 0, 1, 2'd1, 0, 0);
    check("t3_hold", 32'(direction), 3);
    cyc(1, 0, 1, 0, 0, 2'd0, 0, 0);
    run(2, 0);
    check("t3_dir", 32'(direction), 1);

    // 4: both flags, pending step and new tick discarded
    s0 = steps_seen;
    cyc(1, 0, 1, 0, 0, 2'd0, 0, 0);
    cyc(1, 0, 1, 0, 0, 2'd0, 1, 1);
    run(2, 0);
    check("t4_state", 32'(game_state), 3);
    check("t4_steps", steps_seen - s0, 0);

    // 5: end hold
    run(50, 1);
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
    check("t5_early", 32'(game_state), 3);
    run(71, 1);
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
    check("t5_state", 32'(game_state), 0);
    check("t5_dir", 32'(direction), 3);
    check("t5_lrp", 32'(logic_reset_p), 1);

    // 6: pause behaviour
    run(31, 1);
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
    check("t6_state", 32'(game_state), PAUSE_EN ? 2 : 1);
    s0 = steps_seen;
    repeat (3) begin
      cyc(1, 0, 1, 0, 0, 2'd0, 0, 0);
      run(1, 0);
    end
    check("t6_steps", steps_seen - s0, PAUSE_EN ? 0 : 3);
    cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
    check("t6_back", 32'(game_state), 1);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      cyc($urandom_range(0, 599) != 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 0,
          $urandom_range(0, 2) == 0,
          2'($urandom_range(0, 3)),
          $urandom_range(0, 89) == 0,
          $urandom_range(0, 89) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
